// File: rtl/rom_stream_reader_if.sv
// Output stream of rom_stream_reader: 16-bit data with valid/ready handshake and last marker.
interface rom_stream_reader_if;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/rom_stream_reader.sv
// Walks a contiguous 256x16 block-ROM range and streams the words through a 2-entry skid buffer.
// Optional checksum output is enabled by defining ROM_STREAM_CHECKSUM_EN.
module rom_stream_reader (
   input  logic                    clka,
   input  logic                    rsta,
   input  logic                    start,
   input  logic [7:0]              base_addr,
   input  logic [8:0]              count,
   output logic                    ena,
   output logic [7:0]              addra,
   input  logic [15:0]             douta,
   rom_stream_reader_if.master     strm,
   output logic                    busy,
   output logic                    done
`ifdef ROM_STREAM_CHECKSUM_EN
   ,
   output logic [15:0]             checksum
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

   state_e      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [8:0]  remaining_q, remaining_d;
   logic        inflight_q, inflight_d;
   logic        inflight_last_q, inflight_last_d;
   logic [1:0]  fill_q, fill_d;
   logic [15:0] data0_q, data0_d, data1_q, data1_d;
   logic        last0_q, last0_d, last1_q, last1_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
`ifdef ROM_STREAM_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;
`endif

   logic       accept;
   logic       issue;
   logic       pop;
   logic       push;
   logic [2:0] occ_now;
   logic [2:0] occ_limit;

   always_comb begin
      pop       = (fill_q != 2'd0) && strm.out_ready;
      push      = inflight_q;
      accept    = start && (state_q == IDLE);
      occ_now   = {1'b0, fill_q} + {2'b00, inflight_q};
      occ_limit = 3'd2 + {2'b00, pop};
      // fill + inflight - pop < 2, rearranged to stay unsigned
      issue     = (state_q == RUN) && (occ_now < occ_limit);

      state_d         = state_q;
      addr_d          = addr_q;
      remaining_d     = remaining_q;
      inflight_d      = issue;
      inflight_last_d = issue && (remaining_q == 9'd1);
      fill_d          = fill_q;
      data0_d         = data0_q;
      data1_d         = data1_q;
      last0_d         = last0_q;
      last1_d         = last1_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d      = base_addr;
               remaining_d = count;
               state_d     = (count == 9'd0) ? FIN : RUN;
            end
         end
         RUN:     if (issue && (remaining_q == 9'd1)) state_d = DRAIN;
         DRAIN:   if (pop && last0_q) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (issue) begin
         addr_d      = addr_q + 8'd1;
         remaining_d = remaining_q - 9'd1;
      end

      // Slot 0 is always the head; a pop shifts slot 1 forward
      case ({push, pop})
         2'b10: begin
            if (fill_q == 2'd0) begin
               data0_d = douta;
               last0_d = inflight_last_q;
            end else begin
               data1_d = douta;
               last1_d = inflight_last_q;
            end
            fill_d = fill_q + 2'd1;
         end
         2'b01: begin
            data0_d = data1_q;
            last0_d = last1_q;
            last1_d = 1'b0;
            fill_d  = fill_q - 2'd1;
         end
         2'b11: begin
            if (fill_q == 2'd1) begin
               data0_d = douta;
               last0_d = inflight_last_q;
            end else begin
               data0_d = data1_q;
               last0_d = last1_q;
               data1_d = douta;
               last1_d = inflight_last_q;
            end
         end
         default: ;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == FIN);

`ifdef ROM_STREAM_CHECKSUM_EN
      checksum_d = checksum_q;
      if (accept)   checksum_d = '0;
      else if (pop) checksum_d = checksum_q ^ data0_q;
`endif
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fill_q          <= '0;
         data0_q         <= '0;
         data1_q         <= '0;
         last0_q         <= 1'b0;
         last1_q         <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
`ifdef ROM_STREAM_CHECKSUM_EN
         checksum_q      <= '0;
`endif
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remaining_q     <= remaining_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         fill_q          <= fill_d;
         data0_q         <= data0_d;
         data1_q         <= data1_d;
         last0_q         <= last0_d;
         last1_q         <= last1_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
`ifdef ROM_STREAM_CHECKSUM_EN
         checksum_q      <= checksum_d;
`endif
      end
   end

   assign ena            = issue;
   assign addra          = addr_q;
   assign strm.out_data  = data0_q;
   assign strm.out_valid = (fill_q != 2'd0);
   assign strm.out_last  = last0_q;
   assign busy           = busy_q;
   assign done           = done_q;
`ifdef ROM_STREAM_CHECKSUM_EN
   assign checksum       = checksum_q;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: ROM model, queued expected words, decoupled monitor.
module tb_rom_stream_reader;

   logic        clka = 1'b0;
   logic        rsta = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [8:0]  count = '0;
   logic        ena;
   logic [7:0]  addra;
   logic [15:0] douta = '0;
   logic        busy;
   logic        done;
`ifdef ROM_STREAM_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   rom_stream_reader_if strm ();

   rom_stream_reader dut (
      .clka      (clka),
      .rsta      (rsta),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .ena       (ena),
      .addra     (addra),
      .douta     (douta),
      .strm      (strm),
      .busy      (busy),
      .done      (done)
`ifdef ROM_STREAM_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clka = ~clka;

   // ROM model: word[i] = i * 0x0101, one-cycle read latency
   always @(posedge clka) if (ena) douta <= {addra, addra};

   typedef struct { logic [15:0] data; logic last; } exp_t;
   exp_t        sbq[$];
   int          total = 0;
   int          bad = 0;
   int          issued = 0;
   int          popped = 0;
   int          ena_pulses = 0;
   int          lasts_seen = 0;
   logic [7:0]  exp_addr = '0;
   logic [15:0] exp_sum = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected words on every handshake, tracks outstanding reads
   always @(negedge clka) begin
      if (rsta) begin
         issued = 0;
         popped = 0;
      end else begin
         automatic int  occ = issued - popped;
         automatic bit  pop = strm.out_valid && strm.out_ready;
         if (ena) begin
            chk("issue_room", ((occ - int'(pop)) < 2), 1);
            chk("addra_seq", addra, exp_addr);
            exp_addr = exp_addr + 8'd1;
            issued++;
            ena_pulses++;
         end
         if (pop) begin
            if (sbq.size() == 0) begin
               chk("unexpected_word", strm.out_data, 32'hdead_beef);
            end else begin
               automatic exp_t e = sbq.pop_front();
               chk("out_data", strm.out_data, e.data);
               chk("out_last", strm.out_last, e.last);
            end
            if (strm.out_last) lasts_seen++;
            popped++;
         end
      end
   end

   function automatic logic pick_ready(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k < 8) ? ((k % 4 == 0) || (k % 4 == 3)) : ($urandom_range(0, 2) != 0);
         default: return ($urandom_range(0, 3) != 0);
      endcase
   endfunction

   task automatic run_cmd(input logic [7:0] b, input logic [8:0] n, input int mode, input bit poke_fin);
      int done_cyc = -1;
      int first_valid = -1;
      int ni = int'(n);
      @(posedge clka); #1;
      start = 1'b1;
      base_addr = b;
      count = n;
      exp_addr = b;
      ena_pulses = 0;
      lasts_seen = 0;
      exp_sum = '0;
      for (int i = 0; i < ni; i++) begin
         automatic exp_t e;
         automatic logic [7:0] a = b + 8'(i);
         e.data = {a, a};
         e.last = (i == ni - 1);
         exp_sum = exp_sum ^ e.data;
         sbq.push_back(e);
      end
      strm.out_ready = pick_ready(mode, 0);
      for (int k = 1; k <= 3000 && done_cyc < 0; k++) begin
         @(posedge clka); #1;
         start = (poke_fin && k == ni + 3);
         if (start) begin
            base_addr = 8'h55;
            count = 9'd7;
         end
         strm.out_ready = pick_ready(mode, k);
         @(negedge clka);
         if (k == 1) begin
            chk("busy_c1", busy, 1);
            if (ni == 0) begin
               chk("done_c1_cnt0", done, 1);
               chk("ena_c1_cnt0", ena, 0);
            end else begin
               chk("ena_c1", ena, 1);
               chk("addra_c1", addra, b);
            end
         end
         if (strm.out_valid && first_valid < 0) first_valid = k;
         if (done) begin
            done_cyc = k;
`ifdef ROM_STREAM_CHECKSUM_EN
            chk("checksum", checksum, exp_sum);
`endif
         end
      end
      if (done_cyc < 0) chk("done_timeout", 0, 1);
      if (mode == 0) begin
         chk("done_cycle", done_cyc, (ni == 0) ? 1 : ni + 3);
         chk("first_valid", first_valid, (ni == 0) ? -1 : 3);
      end
      chk("ena_pulses", ena_pulses, ni);
      chk("last_count", lasts_seen, (ni == 0) ? 0 : 1);
      chk("queue_empty", sbq.size(), 0);
      @(posedge clka); #1;
      start = 1'b0;
      @(negedge clka);
      chk("idle_busy", busy, 0);
      chk("idle_valid", strm.out_valid, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ena"}, ena, 0);
      chk({tag, "_addra"}, addra, 0);
      chk({tag, "_valid"}, strm.out_valid, 0);
      chk({tag, "_last"}, strm.out_last, 0);
      chk({tag, "_data"}, strm.out_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      strm.out_ready = 1'b0;
      repeat (3) @(posedge clka);
      #1 rsta = 1'b0;
      @(negedge clka);
      check_all_zero("reset");

      run_cmd(8'h10, 9'd4, 0, 1'b1);
      run_cmd(8'hFE, 9'd4, 0, 1'b0);
      run_cmd(8'h00, 9'd0, 0, 1'b0);
      run_cmd(8'h20, 9'd8, 1, 1'b0);
      run_cmd(8'h80, 9'd256, 0, 1'b0);

      // Reset in cycle 5 of a 20-word command
      @(posedge clka); #1;
      start = 1'b1;
      base_addr = 8'h40;
      count = 9'd20;
      exp_addr = 8'h40;
      strm.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         automatic exp_t e;
         automatic logic [7:0] a = 8'h40 + 8'(i);
         e.data = {a, a};
         e.last = (i == 19);
         sbq.push_back(e);
      end
      for (int k = 1; k <= 4; k++) begin
         @(posedge clka); #1;
         start = 1'b0;
      end
      @(posedge clka); #1;
      rsta = 1'b1;
      @(posedge clka); #1;
      rsta = 1'b0;
      sbq.delete();
      @(negedge clka);
      check_all_zero("midreset");

      run_cmd(8'h33, 9'd5, 0, 1'b0);
      for (int r = 0; r < 6; r++) begin
         run_cmd(8'($urandom), 9'($urandom_range(1, 40)), 2, 1'b0);
      end
      run_cmd(8'h11, 9'd3, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
